// File: rtl/fetch_unit_pkg.sv
// Shared fetch-core definitions: word size, NOP encoding, reset address and
// the fetch state encoding.
package fetch_unit_pkg;

  localparam int                XLEN             = 32;
  localparam logic [XLEN-1:0]   NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0]   PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'b00,
    FETCH_WAIT  = 2'b01,
    FETCH_OUT   = 2'b10,
    FETCH_HALT  = 2'b11
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: branch redirect, instruction-memory request/response
// and the decode-side handshake.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            jmp_enable;
  logic [XLEN-1:0] jmp_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            misaligned;

  modport master (
    input  jmp_enable, jmp_addr, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, misaligned
  );

  modport slave (
    output jmp_enable, jmp_addr, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, misaligned
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issue, wait for data, present to
// decode, with branch redirect, in-flight discard and misaligned-target halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            misaligned_q, misaligned_d;

  logic            fire_s;
  logic            jmp_ok_s;
  logic            jmp_bad_s;

  // req_q is only ever high while in ISSUE, so it alone qualifies the grant
  assign fire_s    = req_q & bus.imem_gnt;
  assign jmp_ok_s  = bus.jmp_enable & is_word_aligned(bus.jmp_addr);
  assign jmp_bad_s = bus.jmp_enable & ~is_word_aligned(bus.jmp_addr);

  // Next-state, next-pc and output-register computation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    misaligned_d = misaligned_q;

    if ((state_q != FETCH_HALT) && jmp_bad_s) begin
      state_d      = FETCH_HALT;
      misaligned_d = 1'b1;
      valid_d      = 1'b0;
      discard_d    = 1'b0;
    end else begin
      case (state_q)
        FETCH_ISSUE: begin
          if (fire_s) begin
            state_d   = FETCH_WAIT;
            discard_d = jmp_ok_s;
          end else begin
            state_d   = FETCH_ISSUE;
          end
          if (jmp_ok_s) begin
            pc_d = bus.jmp_addr;
          end else begin
            pc_d = pc_q;
          end
        end
        FETCH_WAIT: begin
          if (bus.imem_rvalid) begin
            discard_d = 1'b0;
            if (jmp_ok_s) begin
              state_d = FETCH_ISSUE;
              pc_d    = bus.jmp_addr;
            end else if (discard_q) begin
              // pc already holds the redirect target
              state_d = FETCH_ISSUE;
              pc_d    = pc_q;
            end else begin
              state_d = FETCH_OUT;
              valid_d = 1'b1;
              instr_d = bus.imem_rdata;
              ipc_d   = pc_q;
              pc_d    = pc_q + PC_STEP;
            end
          end else begin
            state_d   = FETCH_WAIT;
            discard_d = discard_q | jmp_ok_s;
            if (jmp_ok_s) begin
              pc_d = bus.jmp_addr;
            end else begin
              pc_d = pc_q;
            end
          end
        end
        FETCH_OUT: begin
          if (bus.if_ready || jmp_ok_s) begin
            state_d = FETCH_ISSUE;
            valid_d = 1'b0;
          end else begin
            state_d = FETCH_OUT;
          end
          if (jmp_ok_s) begin
            pc_d = bus.jmp_addr;
          end else begin
            pc_d = pc_q;
          end
        end
        FETCH_HALT: begin
          state_d = FETCH_HALT;
          valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH_HALT;
          valid_d = 1'b0;
        end
      endcase
    end

    req_d = (state_d == FETCH_ISSUE);
  end

  // State, pc, discard flag and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_ISSUE;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      ipc_q        <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_instr   = instr_q;
  assign bus.if_pc      = ipc_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a randomised memory/decode environment
// logs grants, handshakes and redirects; each test checks the log against the
// expected instruction stream.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam int EV_GNT = 0;
  localparam int EV_HS  = 1;
  localparam int EV_JMP = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus();
  fetch_unit_if bus2();

  fetch_unit #(.RESET_PC(DEFAULT_RESET_PC)) dut      (.clk(clk), .rst(rst), .bus(bus));
  fetch_unit #(.RESET_PC(WRAP_PC))          dut_wrap (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  ev_t         log_q[$];
  int          cyc;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  int          gnt_pct, ready_pct, jmp_pct, min_lat, max_lat;
  logic        force_en;
  logic [31:0] force_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (force_en && (a == force_addr)) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h3C5A_9617;
  endfunction

  // One clock of environment: log this edge's events, then drive the next cycle.
  task automatic tick();
    ev_t         e;
    logic        fire;
    logic [31:0] faddr;
    fire  = bus.imem_req && bus.imem_gnt;
    faddr = bus.imem_addr;
    if (fire) begin
      e.kind = EV_GNT; e.a = bus.imem_addr; e.d = 32'h0; e.cyc = cyc; log_q.push_back(e);
    end
    if (bus.if_valid && bus.if_ready) begin
      e.kind = EV_HS; e.a = bus.if_pc; e.d = bus.if_instr; e.cyc = cyc; log_q.push_back(e);
    end
    if (bus.jmp_enable) begin
      e.kind = EV_JMP; e.a = bus.jmp_addr; e.d = 32'h0; e.cyc = cyc; log_q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom();
    if (fire) begin
      pend  = 1'b1;
      paddr = faddr;
      cnt   = $urandom_range(max_lat, min_lat);
    end
    if (pend) begin
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(paddr);
        pend            = 1'b0;
      end else begin
        cnt--;
      end
    end
    bus.imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    bus.if_ready = ($urandom_range(99, 0) < ready_pct);
    if ($urandom_range(99, 0) < jmp_pct) begin
      bus.jmp_enable = 1'b1;
      bus.jmp_addr   = $urandom() & 32'hFFFF_FFFC;
    end else begin
      bus.jmp_enable = 1'b0;
      bus.jmp_addr   = $urandom();
    end
  endtask

  task automatic reset_release();
    pend = 1'b0; cnt = 0; force_en = 1'b0; force_addr = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.if_ready = 1'b0; bus.jmp_enable = 1'b0; bus.jmp_addr = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    reset_release();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    tests_run++; if (bus.if_instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000013", bus.if_instr); end
    tests_run++; if (bus.if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", bus.if_pc); end
    tests_run++; if (bus.misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned: got %b want 0", bus.misaligned); end
    tests_run++; if (bus2.if_pc !== WRAP_PC) begin tests_failed++; $display("FAIL reset_pc_param: got %h want %h", bus2.if_pc, WRAP_PC); end
    reset_release();
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL release_req_before_edge: got %b want 0", bus.imem_req); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_stream_basic();
    ev_t hs[$];
    do_reset();
    gnt_pct = 100; ready_pct = 100; jmp_pct = 0; min_lat = 0; max_lat = 0;
    for (int c = 0; c < 40 && hs.size() < 3; c++) begin
      tick();
      hs.delete();
      foreach (log_q[i]) if (log_q[i].kind == EV_HS) hs.push_back(log_q[i]);
    end
    tests_run++;
    if (hs.size() < 3) begin
      tests_failed++; $display("FAIL stream_timeout: got %0d handshakes want 3", hs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (hs[k].a !== 32'(4 * k) || hs[k].d !== mem_word(32'(4 * k))) begin
          tests_failed++;
          $display("FAIL stream_hs%0d: got pc %h instr %h want pc %h instr %h", k, hs[k].a, hs[k].d, 32'(4 * k), mem_word(32'(4 * k)));
        end
      end
      for (int k = 1; k < 3; k++) begin
        tests_run++;
        if (hs[k].cyc - hs[k-1].cyc != 3) begin
          tests_failed++; $display("FAIL stream_spacing%0d: got %0d cycles want 3", k, hs[k].cyc - hs[k-1].cyc);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    logic        found, got_g, got_h;
    logic [31:0] g_addr, h_pc, h_instr;
    int          bad;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      force_en = 1'b1; force_addr = 32'h0;
      gnt_pct = 100; ready_pct = 100; jmp_pct = 0;
      min_lat = (v == 0) ? 0 : 3; max_lat = min_lat;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        if (!bus.imem_req && !bus.if_valid && (pend || bus.imem_rvalid)) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
        tests_failed++; $display("FAIL redir_reach_wait%0d: got no wait state want wait", v);
      end else begin
        log_q.delete();
        bus.jmp_enable = 1'b1; bus.jmp_addr = 32'h0000_0100;
        tick();
        repeat (15) tick();
        got_g = 1'b0; got_h = 1'b0; bad = 0; g_addr = 32'h0; h_pc = 32'h0; h_instr = 32'h0;
        foreach (log_q[i]) begin
          if (log_q[i].kind == EV_GNT && !got_g) begin got_g = 1'b1; g_addr = log_q[i].a; end
          if (log_q[i].kind == EV_HS && !got_h) begin got_h = 1'b1; h_pc = log_q[i].a; h_instr = log_q[i].d; end
          if (log_q[i].kind == EV_HS && log_q[i].d == 32'hDEAD_BEEF) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL redir_stale_data%0d: got %0d stale handshakes want 0", v, bad); end
        tests_run++; if (!got_g || g_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_next_addr%0d: got %h (seen %b) want 00000100", v, g_addr, got_g); end
        tests_run++; if (!got_h || h_pc !== 32'h100 || h_instr !== mem_word(32'h100)) begin tests_failed++; $display("FAIL redir_first_hs%0d: got pc %h instr %h want pc 00000100 instr %h", v, h_pc, h_instr, mem_word(32'h100)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, in0;
    logic        seen;
    do_reset();
    gnt_pct = 100; ready_pct = 0; jmp_pct = 0; min_lat = 0; max_lat = 2;
    for (int c = 0; c < 20 && !bus.if_valid; c++) tick();
    tests_run++;
    if (!bus.if_valid) begin
      tests_failed++; $display("FAIL stall_reach_out: got if_valid 0 want 1");
    end else begin
      pc0 = bus.if_pc; in0 = bus.if_instr;
      tests_run++; if (pc0 !== 32'h0 || in0 !== mem_word(32'h0)) begin tests_failed++; $display("FAIL stall_first: got pc %h instr %h want pc 0 instr %h", pc0, in0, mem_word(32'h0)); end
      for (int k = 0; k < 5; k++) begin
        tick();
        tests_run++;
        if (bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0) || bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_hold%0d: got pc %h instr %h valid %b req %b want pc 0 instr %h valid 1 req 0", k, bus.if_pc, bus.if_instr, bus.if_valid, bus.imem_req, mem_word(32'h0));
        end
      end
      log_q.delete();
      bus.if_ready = 1'b1;
      tick();
      seen = 1'b0;
      foreach (log_q[i]) if (log_q[i].kind == EV_HS && log_q[i].a == 32'h0) seen = 1'b1;
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL stall_release_hs: got none want handshake at 0"); end
      tests_run++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL stall_after_hs: got valid %b req %b want valid 0 req 1", bus.if_valid, bus.imem_req); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] target;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      gnt_pct = 80; ready_pct = 80; jmp_pct = 0; min_lat = 0; max_lat = 3;
      repeat ($urandom_range(15, 4)) tick();
      target = (v == 0) ? 32'h0000_0102 : (($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1)));
      bus.jmp_enable = 1'b1; bus.jmp_addr = target;
      tick();
      tests_run++; if (bus.misaligned !== 1'b1) begin tests_failed++; $display("FAIL misaligned_flag%0d: got %b want 1 (target %h)", v, bus.misaligned, target); end
      gnt_pct = 100; ready_pct = 100;
      for (int k = 0; k < 10; k++) begin
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.misaligned !== 1'b1) begin
          tests_failed++; $display("FAIL misaligned_halt%0d_%0d: got req %b valid %b flag %b want 0 0 1", v, k, bus.imem_req, bus.if_valid, bus.misaligned);
        end
        tick();
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ga[2];
    logic [31:0] hp[2];
    int          ng, nh;
    logic        fire;
    do_reset();
    ga[0] = 32'h0; ga[1] = 32'h0; hp[0] = 32'h0; hp[1] = 32'h0;
    ng = 0; nh = 0;
    bus2.imem_gnt = 1'b1; bus2.if_ready = 1'b1; bus2.imem_rvalid = 1'b0;
    for (int c = 0; c < 40 && (ng < 2 || nh < 2); c++) begin
      fire = bus2.imem_req && bus2.imem_gnt;
      if (fire && ng < 2) begin ga[ng] = bus2.imem_addr; ng++; end
      if (bus2.if_valid && bus2.if_ready && nh < 2) begin hp[nh] = bus2.if_pc; nh++; end
      @(posedge clk); #1;
      bus2.imem_rvalid = fire;
      bus2.imem_rdata  = $urandom();
    end
    bus2.imem_gnt = 1'b0; bus2.if_ready = 1'b0; bus2.imem_rvalid = 1'b0;
    tests_run++;
    if (ng < 2 || nh < 2) begin
      tests_failed++; $display("FAIL wrap_timeout: got %0d grants %0d handshakes want 2 2", ng, nh);
    end else begin
      tests_run++; if (ga[0] !== WRAP_PC) begin tests_failed++; $display("FAIL wrap_first_addr: got %h want %h", ga[0], WRAP_PC); end
      tests_run++; if (ga[1] !== 32'h0) begin tests_failed++; $display("FAIL wrap_second_addr: got %h want 00000000", ga[1]); end
      tests_run++; if (hp[0] !== WRAP_PC || hp[1] !== 32'h0) begin tests_failed++; $display("FAIL wrap_hs_pc: got %h %h want %h 00000000", hp[0], hp[1], WRAP_PC); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int          n_hs;
    logic        got_g, got_h, found;
    logic [31:0] g_addr, h_pc, h_instr;
    do_reset();
    gnt_pct = 100; ready_pct = 100; jmp_pct = 0; min_lat = 4; max_lat = 4;
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      tick();
      n_hs = 0;
      foreach (log_q[i]) if (log_q[i].kind == EV_HS) n_hs++;
      if (n_hs >= 2 && !bus.imem_req && !bus.if_valid && pend) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL rstwait_reach: got no wait state want wait");
    end else begin
      tests_run++; if (bus.if_pc !== 32'h4) begin tests_failed++; $display("FAIL rstwait_pre_pc: got %h want 00000004", bus.if_pc); end
      #3; rst = 1'b1; #1;
      tests_run++;
      if (bus.if_instr !== 32'h0000_0013 || bus.if_pc !== 32'h0 || bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.misaligned !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstwait_async: got instr %h pc %h valid %b req %b flag %b want 00000013 0 0 0 0", bus.if_instr, bus.if_pc, bus.if_valid, bus.imem_req, bus.misaligned);
      end
      reset_release();
      min_lat = 0; max_lat = 1;
      got_g = 1'b0; got_h = 1'b0; g_addr = 32'h0; h_pc = 32'h0; h_instr = 32'h0;
      for (int c = 0; c < 20 && !got_h; c++) begin
        tick();
        foreach (log_q[i]) begin
          if (log_q[i].kind == EV_GNT && !got_g) begin got_g = 1'b1; g_addr = log_q[i].a; end
          if (log_q[i].kind == EV_HS && !got_h) begin got_h = 1'b1; h_pc = log_q[i].a; h_instr = log_q[i].d; end
        end
      end
      tests_run++; if (!got_g || g_addr !== 32'h0) begin tests_failed++; $display("FAIL rstwait_next_addr: got %h (seen %b) want 00000000", g_addr, got_g); end
      tests_run++; if (!got_h || h_pc !== 32'h0 || h_instr !== mem_word(32'h0)) begin tests_failed++; $display("FAIL rstwait_first_hs: got pc %h instr %h want pc 0 instr %h", h_pc, h_instr, mem_word(32'h0)); end
    end
  endtask

  // Stream model: delivered pcs advance by 4 and jump to each redirect target;
  // the grant stream follows the same rule from the last granted address.
  task automatic test_random_redirect();
    logic [31:0] next_fetch, exp_pc;
    int          n_hs;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gnt_pct = $urandom_range(100, 30); ready_pct = $urandom_range(100, 30);
      min_lat = 0; max_lat = $urandom_range(4, 0); jmp_pct = $urandom_range(15, 3);
      repeat (300) tick();
      jmp_pct = 0;
      next_fetch = DEFAULT_RESET_PC; exp_pc = DEFAULT_RESET_PC; n_hs = 0;
      foreach (log_q[i]) begin
        case (log_q[i].kind)
          EV_GNT: begin
            tests_run++;
            if (log_q[i].a !== next_fetch) begin
              tests_failed++; $display("FAIL rand%0d_grant_c%0d: got addr %h want %h", r, log_q[i].cyc, log_q[i].a, next_fetch);
            end
            next_fetch = log_q[i].a + 32'h4;
          end
          EV_HS: begin
            tests_run++;
            if (log_q[i].a !== exp_pc || log_q[i].d !== mem_word(exp_pc)) begin
              tests_failed++; $display("FAIL rand%0d_hs_c%0d: got pc %h instr %h want pc %h instr %h", r, log_q[i].cyc, log_q[i].a, log_q[i].d, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'h4;
            n_hs++;
          end
          EV_JMP: begin
            next_fetch = log_q[i].a;
            exp_pc     = log_q[i].a;
          end
          default: begin
            tests_run++; tests_failed++; $display("FAIL rand%0d_event: got kind %0d want known", r, log_q[i].kind);
          end
        endcase
      end
      tests_run++;
      if (n_hs < 10) begin tests_failed++; $display("FAIL rand%0d_progress: got %0d handshakes want at least 10", r, n_hs); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pend = 1'b0; cnt = 0; paddr = 32'h0; cyc = 0;
    gnt_pct = 0; ready_pct = 0; jmp_pct = 0; min_lat = 0; max_lat = 0;
    force_en = 1'b0; force_addr = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.if_ready = 1'b0; bus.jmp_enable = 1'b0; bus.jmp_addr = 32'h0;
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
    bus2.if_ready = 1'b0; bus2.jmp_enable = 1'b0; bus2.jmp_addr = 32'h0;
    test_reset();
    test_stream_basic();
    test_redirect_wait();
    test_stall();
    test_misaligned();
    test_wrap();
    test_reset_mid_wait();
    test_random_redirect();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL: parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL: jmp_enable  input  1  redirect request from branch controller, sampled at rising clk.
REQ-005 SHALL: jmp_addr  input  32  redirect target, valid when jmp_enable=1.
REQ-006 SHALL: imem_req  output  1  instruction memory read request.
REQ-007 SHALL: imem_addr  output  32  read address, sampled by memory only on the imem_req&imem_gnt cycle.
REQ-008 SHALL: imem_gnt  input  1  memory accepts request this cycle.
REQ-009 SHALL: imem_rvalid  input  1  read data valid, one per granted request, at least 1 cycle after grant.
REQ-010 SHALL: imem_rdata  input  32  read data.
REQ-011 SHALL: if_valid  output  1  fetched instruction available to decode.
REQ-012 SHALL: if_ready  input  1  decode consumes instruction (handshake = if_valid&if_ready).
REQ-013 SHALL: if_instr  output  32  registered instruction word.
REQ-014 SHALL: if_pc  output  32  address of if_instr.
REQ-015 SHALL: misaligned  output  1  sticky flag, redirect target not word-aligned.

Function
REQ-016 SHALL: FSM states ISSUE, WAIT, OUT, HALT; at most one request outstanding.
REQ-017 SHALL: ISSUE -- imem_req=1, imem_addr=pc; on imem_gnt go WAIT, else stay ISSUE.
REQ-018 SHALL: WAIT -- imem_req=0; on imem_rvalid register if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4, go OUT.
REQ-019 SHALL: OUT -- if_valid=1, if_instr/if_pc stable; on if_ready go ISSUE with if_valid=0 next cycle.
REQ-020 SHALL: minimum latency grant-to-if_valid = 1 cycle after rvalid; zero-wait memory gives one instruction per 3 cycles.
REQ-021 SHALL: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000), no flag.
REQ-022 SHALL: jmp_enable with aligned target in any non-HALT state sets pc<=jmp_addr; takes priority over pc+4.
REQ-023 SHALL: redirect in ISSUE without grant -- stay ISSUE, imem_addr=jmp_addr next cycle.
REQ-024 SHALL: redirect in ISSUE with grant, or in WAIT -- set discard flag; the matching rvalid is dropped (no if_valid), then ISSUE at target.
REQ-025 SHALL: redirect in WAIT coincident with imem_rvalid -- data dropped, go ISSUE at target next cycle.
REQ-026 SHALL: redirect in OUT coincident with if_ready -- handshake completes, next request at jmp_addr.
REQ-027 SHALL: redirect in OUT without if_ready -- if_valid drops next cycle, instruction discarded, go ISSUE at target.
REQ-028 SHALL: jmp_enable with jmp_addr[1:0]!=0 -- misaligned<=1, go HALT; HALT drives imem_req=0, if_valid=0 until reset; an outstanding response is absorbed and ignored.

Reset
REQ-029 SHALL: rst asserted asynchronously forces state=ISSUE, pc=RESET_PC, discard=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, misaligned=0, imem_req=0 while rst high.
REQ-030 SHALL: reset mid-WAIT abandons the in-flight request; the memory is required to be reset with the core, so no stale rvalid is accepted.
REQ-031 SHALL: first imem_req=1 with imem_addr=RESET_PC on the first rising edge after rst deasserts.

Structure
REQ-032 SHALL: shared core package holds the fetch state enum, XLEN=32, NOP encoding 32'h0000_0013, default RESET_PC.
REQ-033 SHALL: single module, no sub-module; pc register, discard flag and output register inline.

Verification
REQ-034 SHALL: reset release, gnt same cycle, rvalid next cycle, if_ready=1 -> if_pc 0x0,0x4,0x8 with if_valid every 3rd cycle.
REQ-035 SHALL: jmp_enable=1, jmp_addr=0x100 in WAIT, rvalid with 0xDEADBEEF -> 0xDEADBEEF never presented; next imem_addr=0x100.
REQ-036 SHALL: if_ready=0 for 5 cycles in OUT -> if_instr/if_pc stable, imem_req=0 throughout.
REQ-037 SHALL: redirect to 0x102 -> misaligned=1 next cycle, imem_req=0 and if_valid=0 until rst.
REQ-038 SHALL: RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000.
REQ-039 SHALL: rst pulse mid-WAIT -> outputs reset immediately (asynchronous), next request at RESET_PC.
